// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the M-extension execute unit.
//   md_op_e    - 4-bit ALU control codes for mul/div ops. The ALU decoder uses
//                the same enum, so each code is defined in one place.
//   md_state_e - sequencer states of muldiv_unit.
//   XLEN_DEF   - default operand width; CNT_W_DEF - iteration counter width.
package muldiv_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int CNT_W_DEF = $clog2(XLEN_DEF);

    // REM/REMU share codes with OR/AND; start qualifies them as mul/div ops.
    typedef enum logic [3:0] {
        OP_MUL    = 4'b1010,
        OP_MULH   = 4'b1011,
        OP_MULHSU = 4'b1100,
        OP_MULHU  = 4'b1101,
        OP_DIV    = 4'b1110,
        OP_DIVU   = 4'b1111,
        OP_REM    = 4'b0110,
        OP_REMU   = 4'b0111
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } md_state_e;

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: execute-stage <-> mul/div unit bundle.
//   master (pipeline): drives start, flush, md_op, op_a, op_b;
//                      observes busy, result_valid, result.
//   slave  (muldiv_unit): the reverse.
interface muldiv_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic            flush;
    logic [3:0]      md_op;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            busy;
    logic            result_valid;
    logic [XLEN-1:0] result;

    modport master (
        output start, flush, md_op, op_a, op_b,
        input  busy, result_valid, result
    );

    modport slave (
        input  start, flush, md_op, op_a, op_b,
        output busy, result_valid, result
    );
endinterface

// File: rtl/muldiv_operand_prep.sv
// muldiv_operand_prep: combinational operand conditioning for muldiv_unit.
//   md_op_i            - op code (any code that is not a div/rem op is a multiply)
//   op_a_i, op_b_i     - raw rs1/rs2 values
//   abs_a_o, abs_b_o   - operand magnitudes, taken according to the op's signedness
//   is_div_o, is_rem_o - op class: div/rem vs multiply, and remainder vs quotient
//   mul_hi_o           - the multiply returns the upper half of the product
//   neg_prod_o, neg_quo_o, neg_rem_o - the final result must be negated
//   div0_o, ovf_o      - divide by zero / signed overflow (resolved without iterating)
module muldiv_operand_prep
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [3:0]      md_op_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    output logic [XLEN-1:0] abs_a_o,
    output logic [XLEN-1:0] abs_b_o,
    output logic            is_div_o,
    output logic            is_rem_o,
    output logic            mul_hi_o,
    output logic            neg_prod_o,
    output logic            neg_quo_o,
    output logic            neg_rem_o,
    output logic            div0_o,
    output logic            ovf_o
);
    logic a_sgn, b_sgn, a_neg, b_neg;

    always_comb begin
        is_div_o = 1'b0;
        is_rem_o = 1'b0;
        mul_hi_o = 1'b0;
        a_sgn    = 1'b1;
        b_sgn    = 1'b1;
        case (md_op_e'(md_op_i))
            OP_MULH:   mul_hi_o = 1'b1;
            OP_MULHSU: begin mul_hi_o = 1'b1; b_sgn = 1'b0; end
            OP_MULHU:  begin mul_hi_o = 1'b1; a_sgn = 1'b0; b_sgn = 1'b0; end
            OP_DIV:    is_div_o = 1'b1;
            OP_DIVU:   begin is_div_o = 1'b1; a_sgn = 1'b0; b_sgn = 1'b0; end
            OP_REM:    begin is_div_o = 1'b1; is_rem_o = 1'b1; end
            OP_REMU:   begin is_div_o = 1'b1; is_rem_o = 1'b1; a_sgn = 1'b0; b_sgn = 1'b0; end
            default:   ; // MUL and unknown codes: signed low-half multiply
        endcase
    end

    assign a_neg   = a_sgn & op_a_i[XLEN-1];
    assign b_neg   = b_sgn & op_b_i[XLEN-1];
    assign abs_a_o = a_neg ? (~op_a_i + 1'b1) : op_a_i;
    assign abs_b_o = b_neg ? (~op_b_i + 1'b1) : op_b_i;

    assign neg_prod_o = a_neg ^ b_neg;
    assign neg_quo_o  = a_neg ^ b_neg;
    assign neg_rem_o  = a_neg;

    assign div0_o = is_div_o & (op_b_i == '0);
    // The most negative value divided by -1 is only an overflow for signed ops.
    assign ovf_o  = is_div_o & a_sgn & (op_a_i == {1'b1, {(XLEN-1){1'b0}}}) & (op_b_i == '1);

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative M-extension execute unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
//   clk, rst_n - clock; asynchronous active-low reset
//   bus        - muldiv_if.slave: start/flush/md_op/op_a/op_b in; busy/result_valid/result out
// The multiplier is a radix-2 shift-add and the divider is a restoring divider.
// Each takes one bit per cycle, so an accepted start at T gives result_valid at T+XLEN+1.
// A divide by zero or a signed overflow is resolved at T+1.
// Build option MULDIV_FAST_MUL_EN: multiplies use a single-cycle full-width product
// and complete at T+1.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic     clk,
    input  logic     rst_n,
    muldiv_if.slave  bus
);
    localparam int CW = $clog2(XLEN);

    md_state_e         state_q;
    logic [2*XLEN-1:0] acc_q;     // mul: {partial sum, multiplier}; div: {remainder, dividend/quotient}
    logic [XLEN-1:0]   opnd_q;    // mul: |multiplicand|; div: |divisor|
    logic [CW-1:0]     cnt_q;
    logic              neg_q, hi_q, rem_q, busy_q;
    logic [XLEN-1:0]   pend_q;    // result presented during DONE
    logic [XLEN-1:0]   result_q;  // last delivered result

    logic [XLEN-1:0] abs_a, abs_b;
    logic is_div, is_rem, mul_hi, neg_prod, neg_quo, neg_rem, div0, ovf;

    muldiv_operand_prep #(.XLEN(XLEN)) u_prep (
        .md_op_i   (bus.md_op),
        .op_a_i    (bus.op_a),
        .op_b_i    (bus.op_b),
        .abs_a_o   (abs_a),
        .abs_b_o   (abs_b),
        .is_div_o  (is_div),
        .is_rem_o  (is_rem),
        .mul_hi_o  (mul_hi),
        .neg_prod_o(neg_prod),
        .neg_quo_o (neg_quo),
        .neg_rem_o (neg_rem),
        .div0_o    (div0),
        .ovf_o     (ovf)
    );

    // Shift-add step: add the multiplicand when the multiplier LSB is set, then shift right.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_step;
    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_step = {mul_sum, acc_q[XLEN-1:1]};

    // Restoring step: shift in the next dividend bit and subtract the divisor if it fits.
    // A borrow shows up in the top bit of the difference.
    logic [XLEN:0]     div_sh, div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] div_step;
    assign div_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign div_diff = div_sh - {1'b0, opnd_q};
    assign div_ge   = ~div_diff[XLEN];
    assign div_step = {(div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};

    function automatic logic [XLEN-1:0] sel_mul(input logic [2*XLEN-1:0] p,
                                                input logic neg, input logic hi);
        logic [2*XLEN-1:0] s;
        s = neg ? (~p + 1'b1) : p;
        return hi ? s[2*XLEN-1:XLEN] : s[XLEN-1:0];
    endfunction

    function automatic logic [XLEN-1:0] sel_div(input logic [2*XLEN-1:0] qr,
                                                input logic neg, input logic rem);
        logic [XLEN-1:0] v;
        v = rem ? qr[2*XLEN-1:XLEN] : qr[XLEN-1:0];
        return neg ? (~v + 1'b1) : v;
    endfunction

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    assign fast_prod = {{XLEN{1'b0}}, abs_a} * {{XLEN{1'b0}}, abs_b};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            opnd_q   <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            hi_q     <= 1'b0;
            rem_q    <= 1'b0;
            busy_q   <= 1'b0;
            pend_q   <= '0;
            result_q <= '0;
        end else if (bus.flush) begin
            // Abort from any state; result_q keeps the previously delivered value.
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (bus.start) begin
                    busy_q <= 1'b1;
                    neg_q  <= is_div ? (is_rem ? neg_rem : neg_quo) : neg_prod;
                    hi_q   <= mul_hi;
                    rem_q  <= is_rem;
                    cnt_q  <= CW'(XLEN-1);
                    if (is_div) begin
                        opnd_q <= abs_b;
                        acc_q  <= {{XLEN{1'b0}}, abs_a};
                        if (div0) begin
                            pend_q  <= is_rem ? bus.op_a : '1;
                            state_q <= ST_DONE;
                        end else if (ovf) begin
                            pend_q  <= is_rem ? '0 : bus.op_a;
                            state_q <= ST_DONE;
                        end else begin
                            state_q <= ST_DIV;
                        end
                    end else begin
`ifdef MULDIV_FAST_MUL_EN
                        pend_q  <= sel_mul(fast_prod, neg_prod, mul_hi);
                        state_q <= ST_DONE;
`else
                        opnd_q  <= abs_a;
                        acc_q   <= {{XLEN{1'b0}}, abs_b};
                        state_q <= ST_MUL;
`endif
                    end
                end
                ST_MUL: begin
                    acc_q <= mul_step;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        pend_q  <= sel_mul(mul_step, neg_q, hi_q);
                        state_q <= ST_DONE;
                    end
                end
                ST_DIV: begin
                    acc_q <= div_step;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        pend_q  <= sel_div(div_step, neg_q, rem_q);
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    result_q <= pend_q;
                    busy_q   <= 1'b0;
                    state_q  <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // The valid pulse and the new result are withheld in a DONE cycle that is being flushed.
    logic done_ok;
    assign done_ok          = (state_q == ST_DONE) & ~bus.flush;
    assign bus.busy         = busy_q;
    assign bus.result_valid = done_ok;
    assign bus.result       = done_ok ? pend_q : result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
    import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   ntests = 0;
    int   nfail = 0;

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    muldiv_if #(.XLEN(32)) bus ();
    muldiv_unit #(.XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every result_valid pops one expectation (value and cycle).
    always @(negedge clk) begin
        if (rst_n && bus.result_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                ntests++;
                nfail++;
                $display("FAIL unexpected_valid: got result 0x%08h at cycle %0d, expected none",
                         bus.result, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("result", bus.result, e.res);
                check("latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.md_op = op;
        bus.op_a  = a;
        bus.op_b  = b;
    endtask

    // Presents start for cycle T, then returns #1 into cycle T+1.
    task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit push, input logic [31:0] exp, input int lat, output int t);
        @(posedge clk); #1;
        drive(op, a, b);
        t = cyc;
        if (push) exp_q.push_back('{exp, t + lat});
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            ntests++;
            nfail++;
            $display("FAIL timeout: got %0d pending results, expected 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat);
        int t;
        launch(op, a, b, 1'b1, exp, lat, t);
        drain();
    endtask

    initial begin
        int t;
        logic [31:0] old;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.md_op = 4'b0;
        bus.op_a  = '0;
        bus.op_b  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {31'b0, bus.busy}, 32'h0);
        check("reset_valid", {31'b0, bus.result_valid}, 32'h0);
        check("reset_result", bus.result, 32'h0);
        rst_n = 1'b1;

        // MUL 7 x -3 with busy window checks
        launch(OP_MUL, 32'h7, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFEB, MUL_LAT, t);
        check("busy_T+1", {31'b0, bus.busy}, 32'h1);
        if (MUL_LAT > 1) begin
            repeat (MUL_LAT - 1) @(posedge clk);
            #1;
            check("busy_done", {31'b0, bus.busy}, 32'h1);
        end
        @(posedge clk); #1;
        check("busy_after", {31'b0, bus.busy}, 32'h0);
        drain();

        run(OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT);
        run(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
        run(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT);
        run(OP_MUL,    32'h1234_5678, 32'h9,         32'hA3D7_0A38, MUL_LAT);
        run(4'b0000,   32'h3,         32'h5,         32'hF,         MUL_LAT);
        run(OP_DIV,    32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD, DIV_LAT);
        run(OP_REM,    32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, DIV_LAT);
        run(OP_DIVU,   32'hFFFF_FFFE, 32'h2,         32'h7FFF_FFFF, DIV_LAT);
        run(OP_REMU,   32'd10,        32'd3,         32'h1,         DIV_LAT);
        run(OP_DIV,    32'h7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, DIV_LAT);
        run(OP_REM,    32'h7,         32'hFFFF_FFFE, 32'h1,         DIV_LAT);
        run(OP_DIV,    32'h5,         32'h0,         32'hFFFF_FFFF, 1);
        run(OP_REM,    32'h5,         32'h0,         32'h5,         1);
        run(OP_DIVU,   32'h5,         32'h0,         32'hFFFF_FFFF, 1);
        run(OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run(OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1);

        // Start at T+5 while busy is ignored; original DIVU completes at T+33
        launch(OP_DIVU, 32'd100, 32'd7, 1'b1, 32'd14, DIV_LAT, t);
        repeat (4) @(posedge clk);
        #1;
        drive(OP_MUL, 32'h2, 32'h2);
        @(posedge clk); #1;
        bus.start = 1'b0;
        drain();
        repeat (40) @(posedge clk);
        #1;
        check("ignored_start_result", bus.result, 32'd14);

        // Flush at T+10 of a DIV, start accepted at T+11
        old = bus.result;
        launch(OP_DIV, 32'd100, 32'd7, 1'b0, 32'h0, 0, t);
        repeat (9) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        check("flush_busy", {31'b0, bus.busy}, 32'h0);
        check("flush_result", bus.result, old);
        drive(OP_REMU, 32'd10, 32'd3);
        exp_q.push_back('{32'h1, cyc + DIV_LAT});
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("restart_busy", {31'b0, bus.busy}, 32'h1);
        drain();

        // Flush in the DONE cycle of a divide-by-zero suppresses the pulse
        old = bus.result;
        launch(OP_DIV, 32'h9, 32'h0, 1'b0, 32'h0, 0, t);
        bus.flush = 1'b1;
        #1;
        check("flush_done_valid", {31'b0, bus.result_valid}, 32'h0);
        check("flush_done_result", bus.result, old);
        @(posedge clk); #1;
        bus.flush = 1'b0;
        check("flush_done_busy", {31'b0, bus.busy}, 32'h0);
        check("flush_done_keep", bus.result, old);

        // Asynchronous reset mid-MUL
        launch(OP_MUL, 32'h1234, 32'h5678, 1'b0, 32'h0, 0, t);
        repeat (14) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", {31'b0, bus.busy}, 32'h0);
        check("arst_valid", {31'b0, bus.result_valid}, 32'h0);
        check("arst_result", bus.result, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run(OP_MUL, 32'd6, 32'd7, 32'd42, MUL_LAT);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative M-extension execute unit. Consumes the 4-bit ALU control codes the ALU decoder emits for aluOp=2'b11 and produces MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU results. Sits in the execute stage beside the ALU. Stalls the pipeline through `busy` and returns its result with a one-cycle `result_valid` pulse.

Parameters:
- XLEN, 32, operand/result width (power of 2, >=8)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  launch op; asserted only when aluOp==2'b11 (qualifies md_op, since REM/REMU codes alias OR/AND)
- flush  in  1  abort in-flight op (branch/exception)
- md_op  in  4  1010 MUL, 1011 MULH, 1100 MULHSU, 1101 MULHU, 1110 DIV, 1111 DIVU, 0110 REM, 0111 REMU
- op_a  in  XLEN  rs1 value
- op_b  in  XLEN  rs2 value
- busy  out  1  high from the cycle after an accepted start until the DONE cycle, inclusive
- result_valid  out  1  one-cycle pulse; result is valid in that cycle
- result  out  XLEN  holds the last result until the next result_valid

Behaviour:
- Clock/reset: one clock, clk. Reset is asynchronous, active-low (rst_n). Reset forces IDLE, busy=0, result_valid=0, result=0, and clears all datapath registers.
- States: IDLE, MUL, DIV, DONE.
- IDLE, start=1, flush=0:
  - latch op, sign flags, |a|, |b|, result-negate flag.
  - Mul ops go to MUL. Div/rem ops go to DIV.
  - Special div cases go directly to DONE.
- Start is accepted only in IDLE. Start while busy is ignored, with no queueing.
- Unknown md_op with start: treated as MUL.
- Signedness:
  - MUL/MULH/DIV/REM: both operands signed.
  - MULHSU: a signed, b unsigned.
  - MULHU/DIVU/REMU: both unsigned.
  - Magnitudes are taken before iteration. A 2XLEN product or quotient/remainder is negated at the end when the result sign requires it.
- Result sign rules:
  - Product sign = sign(a) XOR sign(b), restricted to signed operands.
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign(a).
- MUL state: radix-2 shift-add over XLEN cycles (counter XLEN-1 down to 0), 2XLEN accumulator.
  - MUL returns the low XLEN bits.
  - MULH/MULHSU/MULHU return the high XLEN bits.
- DIV state: restoring division, one quotient bit per cycle, XLEN cycles.
- Latency: an accepted start in cycle T gives result_valid in cycle T+XLEN+1 (T+33 for XLEN=32).
- Divide-by-zero (op_b==0), resolved with no iteration, result_valid at T+1:
  - DIV/DIVU: quotient = all ones.
  - REM/REMU: remainder = op_a.
- Signed overflow, DIV/REM with op_a = 0x80000000 and op_b = -1, resolved at T+1:
  - quotient = 0x80000000
  - remainder = 0
- DONE: result_valid=1 for exactly one cycle. result is registered here. Returns to IDLE next cycle, when a new start may be accepted.
- Flush:
  - In any state: go to IDLE next cycle, no result_valid, result keeps its old value.
  - Flush together with start in IDLE: flush wins and start is dropped.
  - Flush in DONE: result_valid in that cycle is suppressed.
- rst_n deasserted mid-operation: immediate abort. The first start after reset behaves as fresh.
- Operands are sampled only at accept. Changes to op_a/op_b while busy have no effect.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined: multiply ops use a single-cycle full-width product. Start at T goes to DONE, result_valid at T+1. Sign handling and result selection are identical. Divide is unchanged.
- Undefined: iterative multiplier as above, XLEN+1 latency, no hardware multiplier inferred.

Decomposition:
- Package muldiv_pkg holds:
  - md_op_e enum with the eight 4-bit codes above, shared with alu_decoder so the codes have one source.
  - md_state_e {IDLE, MUL, DIV, DONE}.
  - Localparams for XLEN default and the counter width $clog2(XLEN).
- One natural sub-module, muldiv_operand_prep (combinational): from md_op, op_a and op_b it produces |a|, |b|, the negate-product / negate-quotient / negate-remainder flags, and the div0/overflow special-case flags.

Test Plan:
- MUL 7 x -3 (0x00000007, 0xFFFFFFFD) -> result_valid exactly at T+33, result 0xFFFFFFEB. busy high T+1..T+33.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. DIVU 0xFFFFFFFE/2 -> 0x7FFFFFFF. REMU 10/3 -> 1. All results at T+33.
- DIV 5/0 -> 0xFFFFFFFF at T+1. REM 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at T+1. REM of the same operands -> 0.
- Flush at T+10 of a DIV -> no result_valid, result unchanged. A start at T+11 is accepted. Start at T+5 while busy is ignored, and the original op completes at T+33.
- rst_n low at T+15 of a MUL -> busy/result_valid/result drop to 0 asynchronously. With MULDIV_FAST_MUL_EN defined, MUL 6 x 7 -> 42 at T+1.
